alu_cond_commit: RTL and testbench
==================================

Name: alu_cond_commit

Overview:
- Execute-stage back end that consumes ALU outputs: `result`, `flags` (bit0=Z, bit1=C, bit2=N, bit3=V) and the ALU writeback-enable signal.
- Holds the architectural NZCV (CPSR flag) register and evaluates each instruction's 4-bit ARM condition field against it.
- Gates flag updates and register-file writeback, and registers the writeback request for the register file one cycle later.
- Sits between the ALU and the register-file write port; decode drives it in parallel with the ALU.

Parameters:
- DATA_W, 32, width of ALU result and writeback data.
- REG_W, 4, width of destination register index.
- CNT_W, 16, width of the executed and skipped instruction counters.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  an instruction is presented this cycle.
- in_cond  input  4  ARM condition field of the instruction.
- in_set_flags  input  1  S bit; update NZCV if the condition passes.
- in_alu_result  input  DATA_W  ALU result.
- in_alu_flags  input  4  ALU flags {V,N,C,Z} packed as bits [3:0] = V,N,C,Z.
- in_alu_wb  input  1  ALU writeback-enable (0 for TST/TEQ/CMP/CMN).
- in_rd  input  REG_W  destination register.
- stall  input  1  hold the stage; no instruction is accepted.
- flush  input  1  kill the input and the registered output.
- in_ready  output  1  combinational; equals !stall && !flush.
- cond_pass  output  1  combinational condition result for the current in_cond vs the current NZCV.
- wb_en  output  1  registered register-file write enable.
- wb_rd  output  REG_W  registered destination register.
- wb_data  output  DATA_W  registered writeback data.
- cpsr_flags  output  4  current NZCV register, same bit order as in_alu_flags.
- exec_count  output  CNT_W  count of accepted instructions whose condition passed.
- skip_count  output  CNT_W  count of accepted instructions whose condition failed.

Behaviour:
- Reset (async, immediate): cpsr_flags=0, wb_en=0, wb_rd=0, wb_data=0, exec_count=0, skip_count=0.
- Accept: an instruction is accepted when in_valid && !stall && !flush.
- Condition decode (Z=f[0], C=f[1], N=f[2], V=f[3] of cpsr_flags):
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V.
  - 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V).
  - E AL 1; F reserved, always fails.
- On accept with cond_pass=1:
  - cpsr_flags <= in_alu_flags if in_set_flags, else unchanged.
  - wb_en <= in_alu_wb; wb_rd <= in_rd; wb_data <= in_alu_result.
  - exec_count increments.
- On accept with cond_pass=0:
  - wb_en <= 0; cpsr_flags unchanged; skip_count increments.
  - wb_rd and wb_data are don't-care; they hold their previous values.
- No accept, stall=1, flush=0: all registers hold, including wb_en. The register file must not double-write; stall is asserted only when the register file is also stalled.
- No accept, in_valid=0, stall=0, flush=0: wb_en <= 0; the other registers hold.
- flush=1 (priority over stall and in_valid): wb_en <= 0; cpsr_flags and counters unchanged.
- Flag hazard:
  - Back-to-back flag setter then conditional instruction: the second instruction sees the updated cpsr_flags, because the update is registered at the first instruction's accept edge and evaluation reads the register in the following cycle.
  - No bypass of in_alu_flags into cond_pass.
- Latency: writeback is visible exactly 1 cycle after accept; NZCV is visible 1 cycle after accept.
- Counters: saturate at all-ones and never wrap.
- Reset asserted mid-stream: all state clears immediately. The first accept after deassertion evaluates against NZCV=0, so EQ fails and NE passes.

Test Plan:
1. Reset, then accept cond=E, set_flags=1, alu_flags=4'b0001, result=0, wb=1, rd=3 -> next cycle cpsr_flags=0001, wb_en=1, wb_rd=3, wb_data=0, exec_count=1.
2. With Z=1, accept cond=1 (NE), result=5 -> cond_pass=0, wb_en=0 next cycle, skip_count increments, cpsr_flags unchanged.
3. Back-to-back flag test:
   - Cycle 0: CMP-like instruction, wb=0, set_flags=1, flags N=1, V=0.
   - Cycle 1: cond=B (LT), result=7, rd=2.
   - Required: wb_en=0 after cycle 0, then wb_en=1, wb_data=7, wb_rd=2.
4. Sweep all 16 cond codes against each of the 16 NZCV values -> cond_pass matches the decode table; cond=F always fails.
5. Stall/flush priority:
   - stall=1 with in_valid=1: outputs and counters hold.
   - stall=1 and flush=1 together: wb_en=0 and cpsr_flags unchanged.
6. Preload exec_count to 16'hFFFE, then accept 3 passing instructions -> exec_count=16'hFFFF. Assert reset mid-stream -> all outputs 0 without waiting for a clock edge.

Source files
------------

// File: rtl/alu_cond_commit.sv
`default_nettype none
// ============================================================================
//  Module      : alu_cond_commit
//  Description : Execute-stage back end. Holds the NZCV flag register,
//                evaluates the ARM condition field of each instruction
//                against it, gates flag updates and register-file
//                writeback, and registers the writeback request one cycle
//                after accept. Also keeps saturating executed/skipped counts.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_cond_commit #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [3:0]        in_cond,
    input  logic              in_set_flags,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [3:0]        in_alu_flags,
    input  logic              in_alu_wb,
    input  logic [REG_W-1:0]  in_rd,
    input  logic              stall,
    input  logic              flush,
    output logic              in_ready,
    output logic              cond_pass,
    output logic              wb_en,
    output logic [REG_W-1:0]  wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic [3:0]        cpsr_flags,
    output logic [CNT_W-1:0]  exec_count,
    output logic [CNT_W-1:0]  skip_count
);

    // Condition field encodings
    localparam logic [3:0] C_COND_EQ = 4'h0;
    localparam logic [3:0] C_COND_NE = 4'h1;
    localparam logic [3:0] C_COND_CS = 4'h2;
    localparam logic [3:0] C_COND_CC = 4'h3;
    localparam logic [3:0] C_COND_MI = 4'h4;
    localparam logic [3:0] C_COND_PL = 4'h5;
    localparam logic [3:0] C_COND_VS = 4'h6;
    localparam logic [3:0] C_COND_VC = 4'h7;
    localparam logic [3:0] C_COND_HI = 4'h8;
    localparam logic [3:0] C_COND_LS = 4'h9;
    localparam logic [3:0] C_COND_GE = 4'hA;
    localparam logic [3:0] C_COND_LT = 4'hB;
    localparam logic [3:0] C_COND_GT = 4'hC;
    localparam logic [3:0] C_COND_LE = 4'hD;
    localparam logic [3:0] C_COND_AL = 4'hE;

    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    logic [3:0]        r_cpsr;
    logic              r_wb_en;
    logic [REG_W-1:0]  r_wb_rd;
    logic [DATA_W-1:0] r_wb_data;
    logic [CNT_W-1:0]  r_exec_cnt;
    logic [CNT_W-1:0]  r_skip_cnt;

    logic w_z, w_c, w_n, w_v;
    logic w_pass;
    logic w_ready;
    logic w_accept;

    // Flag bits come straight from the architectural register; the incoming
    // ALU flags are never bypassed into the condition check.
    assign w_z = r_cpsr[0];
    assign w_c = r_cpsr[1];
    assign w_n = r_cpsr[2];
    assign w_v = r_cpsr[3];

    assign w_ready  = !stall && !flush;
    assign w_accept = in_valid && w_ready;

    // Decode the condition field against the current NZCV register
    always_comb begin
        w_pass = 1'b0;
        case (in_cond)
            C_COND_EQ: w_pass = w_z;
            C_COND_NE: w_pass = !w_z;
            C_COND_CS: w_pass = w_c;
            C_COND_CC: w_pass = !w_c;
            C_COND_MI: w_pass = w_n;
            C_COND_PL: w_pass = !w_n;
            C_COND_VS: w_pass = w_v;
            C_COND_VC: w_pass = !w_v;
            C_COND_HI: w_pass = w_c && !w_z;
            C_COND_LS: w_pass = !w_c || w_z;
            C_COND_GE: w_pass = (w_n == w_v);
            C_COND_LT: w_pass = (w_n != w_v);
            C_COND_GT: w_pass = !w_z && (w_n == w_v);
            C_COND_LE: w_pass = w_z || (w_n != w_v);
            C_COND_AL: w_pass = 1'b1;
            default:   w_pass = 1'b0;   // 4'hF is reserved and never executes
        endcase
    end

    // NZCV register: updated only by an accepted, passing, flag-setting op
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cpsr <= 4'b0000;
        end else if (w_accept && w_pass && in_set_flags) begin
            r_cpsr <= in_alu_flags;
        end
    end

    // Writeback enable: a stall freezes it so the request stays aligned with
    // the stalled register file; flush, bubbles and failed conditions clear it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wb_en <= 1'b0;
        end else if (flush) begin
            r_wb_en <= 1'b0;
        end else if (!stall) begin
            r_wb_en <= w_accept && w_pass && in_alu_wb;
        end
    end

    // Writeback payload is captured only for passing instructions; otherwise
    // it holds its previous value (contents are don't-care while wb_en is low)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wb_rd   <= '0;
            r_wb_data <= '0;
        end else if (w_accept && w_pass) begin
            r_wb_rd   <= in_rd;
            r_wb_data <= in_alu_result;
        end
    end

    // Executed-instruction counter, saturating at all-ones
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_exec_cnt <= '0;
        end else if (w_accept && w_pass && (r_exec_cnt != C_CNT_MAX)) begin
            r_exec_cnt <= r_exec_cnt + C_CNT_ONE;
        end
    end

    // Skipped-instruction counter, saturating at all-ones
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_skip_cnt <= '0;
        end else if (w_accept && !w_pass && (r_skip_cnt != C_CNT_MAX)) begin
            r_skip_cnt <= r_skip_cnt + C_CNT_ONE;
        end
    end

    assign in_ready   = w_ready;
    assign cond_pass  = w_pass;
    assign wb_en      = r_wb_en;
    assign wb_rd      = r_wb_rd;
    assign wb_data    = r_wb_data;
    assign cpsr_flags = r_cpsr;
    assign exec_count = r_exec_cnt;
    assign skip_count = r_skip_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alu_cond_commit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_cond_commit
//  Description : Scoreboard bench for alu_cond_commit. A driver issues
//                directed and random instructions and pushes the reference
//                model's expected response; a monitor pops and compares.
//                A second instance with 4-bit counters shares the inputs so
//                counter saturation is reached quickly.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_cond_commit;

    localparam int C_SMALL_MAX = 15;
    localparam int C_BIG_MAX   = 65535;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [3:0]  in_cond;
    logic        in_set_flags;
    logic [31:0] in_alu_result;
    logic [3:0]  in_alu_flags;
    logic        in_alu_wb;
    logic [3:0]  in_rd;
    logic        stall;
    logic        flush;

    logic        in_ready,  in_ready_s;
    logic        cond_pass, cond_pass_s;
    logic        wb_en,     wb_en_s;
    logic [3:0]  wb_rd,     wb_rd_s;
    logic [31:0] wb_data,   wb_data_s;
    logic [3:0]  cpsr_flags, cpsr_flags_s;
    logic [15:0] exec_count, skip_count;
    logic [3:0]  exec_count_s, skip_count_s;

    alu_cond_commit #(.DATA_W(32), .REG_W(4), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_cond(in_cond),
        .in_set_flags(in_set_flags), .in_alu_result(in_alu_result),
        .in_alu_flags(in_alu_flags), .in_alu_wb(in_alu_wb), .in_rd(in_rd),
        .stall(stall), .flush(flush), .in_ready(in_ready), .cond_pass(cond_pass),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .cpsr_flags(cpsr_flags),
        .exec_count(exec_count), .skip_count(skip_count)
    );

    alu_cond_commit #(.DATA_W(32), .REG_W(4), .CNT_W(4)) u_dut_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_cond(in_cond),
        .in_set_flags(in_set_flags), .in_alu_result(in_alu_result),
        .in_alu_flags(in_alu_flags), .in_alu_wb(in_alu_wb), .in_rd(in_rd),
        .stall(stall), .flush(flush), .in_ready(in_ready_s), .cond_pass(cond_pass_s),
        .wb_en(wb_en_s), .wb_rd(wb_rd_s), .wb_data(wb_data_s), .cpsr_flags(cpsr_flags_s),
        .exec_count(exec_count_s), .skip_count(skip_count_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        ready;
        logic        pass;
        logic        wb_en;
        logic [3:0]  rd;
        logic [31:0] data;
        logic [3:0]  cpsr;
        int          ex;
        int          sk;
        int          ex_s;
        int          sk_s;
    } exp_t;

    exp_t q[$];

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    logic [3:0]  m_cpsr;
    logic        m_wb;
    logic [3:0]  m_rd;
    logic [31:0] m_data;
    int          m_ex, m_sk, m_ex_s, m_sk_s;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Conditions come in complementary pairs: even code tests a predicate,
    // the following odd code tests its negation; 14 always, 15 never.
    function automatic bit model_pass(input int c, input logic [3:0] f);
        bit z, cy, n, v, base;
        z = f[0]; cy = f[1]; n = f[2]; v = f[3];
        base = 1'b0;
        if (c == 14) return 1'b1;
        if (c == 15) return 1'b0;
        case (c / 2)
            0: base = z;
            1: base = cy;
            2: base = n;
            3: base = v;
            4: base = cy && !z;
            5: base = (n == v);
            default: base = !z && (n == v);
        endcase
        return (c % 2 == 1) ? !base : base;
    endfunction

    task automatic model_reset();
        m_cpsr = 4'h0; m_wb = 1'b0; m_rd = 4'h0; m_data = 32'h0;
        m_ex = 0; m_sk = 0; m_ex_s = 0; m_sk_s = 0;
    endtask

    task automatic drive(input bit v, input logic [3:0] c, input bit sf,
                         input logic [31:0] res, input logic [3:0] fl, input bit wb,
                         input logic [3:0] rd, input bit st, input bit fs);
        exp_t e;
        bit   p;
        @(negedge clk);
        in_valid = v; in_cond = c; in_set_flags = sf; in_alu_result = res;
        in_alu_flags = fl; in_alu_wb = wb; in_rd = rd; stall = st; flush = fs;
        p = model_pass(int'(c), m_cpsr);
        e.ready = !st && !fs;
        e.pass  = p;
        if (fs) begin
            m_wb = 1'b0;
        end else if (st) begin
            m_wb = m_wb;
        end else if (v) begin
            if (p) begin
                if (sf) m_cpsr = fl;
                m_wb = wb; m_rd = rd; m_data = res;
                if (m_ex < C_BIG_MAX)   m_ex++;
                if (m_ex_s < C_SMALL_MAX) m_ex_s++;
            end else begin
                m_wb = 1'b0;
                if (m_sk < C_BIG_MAX)   m_sk++;
                if (m_sk_s < C_SMALL_MAX) m_sk_s++;
            end
        end else begin
            m_wb = 1'b0;
        end
        e.wb_en = m_wb; e.rd = m_rd; e.data = m_data; e.cpsr = m_cpsr;
        e.ex = m_ex; e.sk = m_sk; e.ex_s = m_ex_s; e.sk_s = m_sk_s;
        q.push_back(e);
    endtask

    // Monitor: combinational outputs before the edge, registered ones after
    initial begin
        exp_t it;
        forever begin
            @(negedge clk);
            #1;
            if (q.size() != 0) begin
                it = q[0];
                chk("in_ready",  64'(in_ready),  64'(it.ready));
                chk("cond_pass", 64'(cond_pass), 64'(it.pass));
                @(posedge clk);
                #1;
                chk("wb_en",        64'(wb_en),        64'(it.wb_en));
                if (it.wb_en) begin
                    chk("wb_rd",    64'(wb_rd),        64'(it.rd));
                    chk("wb_data",  64'(wb_data),      64'(it.data));
                end
                chk("cpsr_flags",   64'(cpsr_flags),   64'(it.cpsr));
                chk("exec_count",   64'(exec_count),   64'(it.ex));
                chk("skip_count",   64'(skip_count),   64'(it.sk));
                chk("exec_count_s", 64'(exec_count_s), 64'(it.ex_s));
                chk("skip_count_s", 64'(skip_count_s), 64'(it.sk_s));
                void'(q.pop_front());
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_cpsr"},  64'(cpsr_flags),   64'h0);
        chk({tag, "_wb_en"}, 64'(wb_en),        64'h0);
        chk({tag, "_wb_rd"}, 64'(wb_rd),        64'h0);
        chk({tag, "_wbdat"}, 64'(wb_data),      64'h0);
        chk({tag, "_exec"},  64'(exec_count),   64'h0);
        chk({tag, "_skip"},  64'(skip_count),   64'h0);
        chk({tag, "_exs"},   64'(exec_count_s), 64'h0);
        chk({tag, "_sks"},   64'(skip_count_s), 64'h0);
    endtask

    initial begin
        logic [3:0] rc;
        in_valid = 0; in_cond = 0; in_set_flags = 0; in_alu_result = 0;
        in_alu_flags = 0; in_alu_wb = 0; in_rd = 0; stall = 0; flush = 0;
        reset = 1'b1;
        model_reset();
        #1;
        check_all_zero("rst");
        @(negedge clk);
        reset = 1'b0;

        // Flag setter under AL, then NE against Z=1
        drive(1, 4'hE, 1, 32'h0, 4'b0001, 1, 4'd3, 0, 0);
        drive(1, 4'h1, 0, 32'h5, 4'b0000, 1, 4'd6, 0, 0);

        // Compare-like setter followed immediately by LT
        drive(1, 4'hE, 1, 32'h1234, 4'b0100, 0, 4'd9, 0, 0);
        drive(1, 4'hB, 0, 32'h7,    4'b0000, 1, 4'd2, 0, 0);

        // Stall holds, stall+flush clears wb_en, plain bubble clears wb_en
        drive(1, 4'hE, 1, 32'hAAAA, 4'b1111, 1, 4'd1, 1, 0);
        drive(1, 4'hE, 1, 32'hBBBB, 4'b1111, 1, 4'd1, 1, 1);
        drive(1, 4'hE, 0, 32'hCCCC, 4'b0000, 1, 4'd4, 0, 0);
        drive(0, 4'hE, 1, 32'hDDDD, 4'b1010, 1, 4'd5, 0, 0);
        drive(1, 4'hE, 0, 32'hEEEE, 4'b0000, 1, 4'd7, 0, 1);

        // Every condition code against every NZCV value
        for (int f = 0; f < 16; f++) begin
            drive(1, 4'hE, 1, 32'(f), 4'(f), 1, 4'(f), 0, 0);
            for (int c = 0; c < 16; c++)
                drive(0, 4'(c), 0, 32'h0, 4'h0, 0, 4'h0, 0, 0);
        end

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rc = ($urandom_range(0, 2) == 0) ? 4'hE : 4'($urandom_range(0, 15));
            drive($urandom_range(0, 3) != 0, rc, $urandom_range(0, 1) == 1,
                  $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0,
                  4'($urandom_range(0, 15)), $urandom_range(0, 9) == 0,
                  $urandom_range(0, 12) == 0);
        end

        // More passing instructions once counters are saturated
        for (int i = 0; i < 3; i++)
            drive(1, 4'hE, 0, 32'(100 + i), 4'h0, 1, 4'(i), 0, 0);

        // Asynchronous reset mid-cycle, checked before any clock edge
        @(negedge clk);
        in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all_zero("async_rst");
        @(negedge clk);
        reset = 1'b0;

        // First accepts after reset see NZCV=0: EQ fails, NE passes
        drive(1, 4'h0, 0, 32'h11, 4'h0, 1, 4'd8, 0, 0);
        drive(1, 4'h1, 0, 32'h22, 4'h0, 1, 4'd9, 0, 0);

        for (int k = 0; k < 20 && q.size() != 0; k++)
            @(negedge clk);
        chk("drain_queue", 64'(q.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
